// File: rtl/m1rstreq.sv
// Reset-request generator: merges debounced button, soft request and watchdog
// timeout into one fixed-length trigger_reset pulse plus a hold-off window.
module m1rstreq #(
  parameter logic [19:0] DEB_CYCLES = 20'd1000000,
  parameter int          WDT_WIDTH  = 32,
  parameter int          PULSE_LEN  = 16,
  parameter int          HOLDOFF    = 256
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 btn_n,
  input  logic                 soft_req,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic [WDT_WIDTH-1:0] wdt_load,
  input  logic                 cause_clr,
  output logic                 trigger_reset,
  output logic [2:0]           reset_cause,
  output logic [WDT_WIDTH-1:0] wdt_count
);

  localparam int MAXC = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD
  } state_t;

  // ---------------- button synchronizer and debouncer ----------------
  logic        btn_s1;
  logic        btn_s2;
  logic        btn_deb;
  logic        btn_evt;
  logic [19:0] deb_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      btn_deb <= 1'b1;
      deb_cnt <= '0;
      btn_evt <= 1'b0;
    end else begin
      btn_s1  <= btn_n;
      btn_s2  <= btn_s1;
      btn_evt <= 1'b0;
      if (btn_s2 == btn_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_CYCLES - 20'd1) begin
        // Accept the new level; only the press edge (going low) is an event.
        deb_cnt <= '0;
        btn_deb <= btn_s2;
        btn_evt <= ~btn_s2;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end
  end

  // ---------------- watchdog ----------------
  logic wdt_evt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdt_count <= '1;
      wdt_evt   <= 1'b0;
    end else begin
      wdt_evt <= 1'b0;
      if (!wdt_en || wdt_kick) begin
        wdt_count <= wdt_load;
      end else if (wdt_count == '0) begin
        wdt_evt   <= 1'b1;
        wdt_count <= wdt_load;
      end else begin
        wdt_count <= wdt_count - WDT_WIDTH'(1);
      end
    end
  end

  // ---------------- pulse / hold-off FSM ----------------
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          trig_next;
  logic [2:0]    cause_next;
  logic [2:0]    new_bits;

  assign new_bits = {wdt_evt, soft_req, btn_evt};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      trigger_reset <= 1'b0;
      reset_cause   <= 3'b000;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      trigger_reset <= trig_next;
      reset_cause   <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    trig_next  = 1'b0;
    cause_next = cause_clr ? 3'b000 : reset_cause;
    case (state)
      IDLE: begin
        if (|new_bits) begin
          // Clear and new bits in one cycle: the new set replaces the old.
          state_next = PULSE;
          cnt_next   = '0;
          trig_next  = 1'b1;
          cause_next = cause_next | new_bits;
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next  = cnt + CW'(1);
          trig_next = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
